inst_fetch: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the instruction ROM and directly downstream into the IF/ID boundary.
- Owns the program counter and drives the ROM chip-enable and byte address.
- Captures the combinational ROM word into a small fetch buffer and presents {pc, inst} to decode with a valid/ready handshake.
- Handles decode back-pressure and branch redirect (flush).

---
 rtl/inst_fetch_pkg.sv | 24 ++
 rtl/fetch_buf.sv | 74 +++++++
 rtl/inst_fetch.sv | 86 ++++++++
 tb/tb_inst_fetch.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared widths, enable constants and buffer state encoding for the instruction fetch front end.
// The optional redirect alignment check is enabled with INST_FETCH_MISALIGN_CHECK_EN.
package inst_fetch_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 64;

    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;
    localparam logic RstEnable   = 1'b1;

    localparam logic [InstAddrBus-1:0] ZeroWord       = '0;
    localparam logic [InstBus-1:0]     ZeroDoubleWord = '0;

    // One instruction occupies 8 bytes of ROM.
    localparam int InstStride = 8;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_FILL  = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/fetch_buf.sv
// Synchronous FIFO between ROM capture and decode; the head is registered so decode
// never sees a combinational path from the ROM.
module fetch_buf
    import inst_fetch_pkg::*;
#(
    parameter int W     = 96,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     wdata,
    output logic [CNT_W-1:0] count,
    output logic [W-1:0]     head,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    buf_state_e       state;

    assign full = (state == BUF_FULL);

    always_ff @(posedge clk) begin
        if (push && !clear && rst != RstEnable)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
            state  <= BUF_EMPTY;
        end else if (clear) begin
            // Head keeps its last value; decode ignores it while empty.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            state  <= BUF_EMPTY;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);

            if (pop && count > CNT_W'(1))
                head <= mem[rd_ptr + PTR_W'(1)];
            else if (push && (count == '0 || pop))
                head <= wdata;

            case (state)
                BUF_EMPTY: if (push) state <= BUF_FILL;
                BUF_FILL: begin
                    if (push && !pop && count == CNT_W'(DEPTH - 1))
                        state <= BUF_FULL;
                    else if (pop && !push && count == CNT_W'(1))
                        state <= BUF_EMPTY;
                end
                BUF_FULL: if (pop && !push) state <= BUF_FILL;
                default: state <= BUF_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC and ROM enable, buffers {pc, inst} for decode.
// Define INST_FETCH_MISALIGN_CHECK_EN to flag and align unaligned redirect targets.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                ADDR_W   = InstAddrBus,
    parameter int                INST_W   = InstBus,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [INST_W-1:0] rom_inst_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              id_valid_o,
    input  logic              id_ready_i,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic              misalign_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0]        pc;
    logic [ADDR_W-1:0]        target;
    logic [CNT_W-1:0]         count;
    logic                     full;
    logic                     pop;
    logic                     fetch;
    logic [ADDR_W+INST_W-1:0] head;

    assign rom_addr_o = pc;
    assign id_valid_o = (count != '0);
    assign pop        = id_valid_o & id_ready_i;
    assign fetch      = rom_ce_o & (~full | pop) & ~flush_i;
    assign id_pc_o    = head[ADDR_W+INST_W-1:INST_W];
    assign id_inst_o  = head[INST_W-1:0];

`ifdef INST_FETCH_MISALIGN_CHECK_EN
    assign target = {redirect_pc_i[ADDR_W-1:3], 3'b000};

    always_ff @(posedge clk) begin
        if (rst == RstEnable)
            misalign_o <= 1'b0;
        else if (flush_i)
            misalign_o <= (redirect_pc_i[2:0] != 3'b000);
    end
`else
    assign target     = redirect_pc_i;
    assign misalign_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            pc       <= RESET_PC;
            rom_ce_o <= ChipDisable;
        end else begin
            rom_ce_o <= ChipEnable;
            // Redirect wins even before the ROM is enabled.
            if (flush_i)
                pc <= target;
            else if (fetch)
                pc <= pc + ADDR_W'(InstStride);
        end
    end

    fetch_buf #(
        .W     (ADDR_W + INST_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .clear (flush_i),
        .push  (fetch),
        .pop   (pop & ~flush_i),
        .wdata ({pc, rom_inst_i}),
        .count (count),
        .head  (head),
        .full  (full)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed plus randomized bench for inst_fetch against a queue-based fetch model.
module tb_inst_fetch;

    localparam int DEPTH = 2;
`ifdef INST_FETCH_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [63:0] rom_inst_i;
    logic        flush_i;
    logic [31:0] redirect_pc_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_pc_o;
    logic [63:0] id_inst_o;
    logic        misalign_o;

    int checks = 0;
    int errors = 0;

    inst_fetch #(.ADDR_W(32), .INST_W(64), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .rom_ce_o      (rom_ce_o),
        .rom_addr_o    (rom_addr_o),
        .rom_inst_i    (rom_inst_i),
        .flush_i       (flush_i),
        .redirect_pc_i (redirect_pc_i),
        .id_valid_o    (id_valid_o),
        .id_ready_i    (id_ready_i),
        .id_pc_o       (id_pc_o),
        .id_inst_o     (id_inst_o),
        .misalign_o    (misalign_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] rom_word(input logic [31:0] a);
        if (a == 32'h0)  return 64'h2080c00000000000;
        if (a == 32'h10) return 64'h10b1844000000000;
        return {a ^ 32'hA5A5_5A5A, ~a};
    endfunction

    assign rom_inst_i = rom_word(rom_addr_o);

    typedef struct {
        logic [31:0] pc;
        logic [63:0] inst;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc;
    logic        m_ce;
    logic        m_mis;
    logic [31:0] m_last_pc;
    logic [63:0] m_last_inst;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge given the inputs applied this cycle.
    task automatic model_edge(input bit r, input bit f, input logic [31:0] rp, input bit rdy);
        bit pop, room, fetch;
        if (r) begin
            m_pc = 32'h0; m_ce = 1'b0; m_mis = 1'b0;
            q.delete();
            m_last_pc = '0; m_last_inst = '0;
            return;
        end
        pop   = (q.size() != 0) && rdy;
        room  = (q.size() < DEPTH) || pop;
        fetch = m_ce && room && !f;
        if (f) begin
            q.delete();
            m_pc = MIS_EN ? {rp[31:3], 3'b000} : rp;
            if (MIS_EN) m_mis = (rp[2:0] != 3'b000);
        end else begin
            if (pop) void'(q.pop_front());
            if (fetch) begin
                q.push_back('{pc: m_pc, inst: rom_word(m_pc)});
                m_pc = m_pc + 32'd8;
            end
        end
        m_ce = 1'b1;
        if (q.size() != 0) begin
            m_last_pc   = q[0].pc;
            m_last_inst = q[0].inst;
        end
    endtask

    // Apply inputs at the falling edge, clock once, compare at the next falling edge.
    task automatic cyc(input bit r, input bit f, input logic [31:0] rp, input bit rdy);
        rst = r; flush_i = f; redirect_pc_i = rp; id_ready_i = rdy;
        model_edge(r, f, rp, rdy);
        @(posedge clk);
        @(negedge clk);
        chk("ce",    rom_ce_o,   m_ce);
        chk("addr",  rom_addr_o, m_pc);
        chk("valid", id_valid_o, q.size() != 0);
        chk("pc",    id_pc_o,    m_last_pc);
        chk("inst",  id_inst_o,  m_last_inst);
        chk("mis",   misalign_o, m_mis);
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; redirect_pc_i = '0; id_ready_i = 1'b1;
        m_pc = '0; m_ce = 1'b0; m_mis = 1'b0; m_last_pc = '0; m_last_inst = '0;

        // Reset state
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);
        chk("rst_ce", rom_ce_o, 0);
        chk("rst_valid", id_valid_o, 0);
        chk("rst_id_pc", id_pc_o, 0);
        chk("rst_id_inst", id_inst_o, 0);
        chk("rst_mis", misalign_o, 0);

        // Free run
        cyc(0, 0, 0, 1);
        chk("run_ce_rise", rom_ce_o, 1);
        chk("run_valid_lo", id_valid_o, 0);
        cyc(0, 0, 0, 1);
        chk("run_valid", id_valid_o, 1);
        chk("run_pc0", id_pc_o, 32'h0);
        chk("run_inst0", id_inst_o, 64'h2080c00000000000);
        cyc(0, 0, 0, 1);
        chk("run_pc8", id_pc_o, 32'h8);
        cyc(0, 0, 0, 1);
        chk("run_pc10", id_pc_o, 32'h10);
        chk("run_inst10", id_inst_o, 64'h10b1844000000000);

        // Back-pressure from reset
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
        chk("bp_addr_hold", rom_addr_o, 32'h10);
        chk("bp_head", id_pc_o, 32'h0);
        chk("bp_valid", id_valid_o, 1);
        cyc(0, 0, 0, 1);
        chk("bp_rel_pc8", id_pc_o, 32'h8);
        cyc(0, 0, 0, 1);
        chk("bp_rel_pc10", id_pc_o, 32'h10);

        // Flush while full
        cyc(0, 1, 32'h40, 0);
        chk("fl_valid_lo", id_valid_o, 0);
        cyc(0, 0, 0, 1);
        chk("fl_valid", id_valid_o, 1);
        chk("fl_pc40", id_pc_o, 32'h40);
        cyc(0, 0, 0, 1);
        chk("fl_pc48", id_pc_o, 32'h48);

        // Flush and pop together
        cyc(0, 1, 32'h80, 1);
        chk("flp_valid_lo", id_valid_o, 0);
        cyc(0, 0, 0, 1);
        chk("flp_pc80", id_pc_o, 32'h80);

        // PC wrap
        cyc(0, 1, 32'hFFFF_FFF8, 1);
        cyc(0, 0, 0, 1);
        chk("wrap_top", id_pc_o, 32'hFFFF_FFF8);
        cyc(0, 0, 0, 1);
        chk("wrap_zero", id_pc_o, 32'h0);

        // Reset mid-stream with a full buffer
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("mrst_ce", rom_ce_o, 0);
        chk("mrst_valid", id_valid_o, 0);
        chk("mrst_pc", id_pc_o, 0);
        chk("mrst_addr", rom_addr_o, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("mrst_restart", id_pc_o, 32'h0);

        // Redirect before the ROM is enabled
        cyc(1, 0, 0, 1);
        cyc(0, 1, 32'h100, 1);
        chk("ce0_flush_addr", rom_addr_o, 32'h100);
        cyc(0, 0, 0, 1);
        chk("ce0_flush_pc", id_pc_o, 32'h100);

`ifdef INST_FETCH_MISALIGN_CHECK_EN
        cyc(0, 1, 32'h44, 1);
        chk("mis_set", misalign_o, 1);
        cyc(0, 0, 0, 1);
        chk("mis_pc40", id_pc_o, 32'h40);
        cyc(0, 1, 32'h48, 1);
        chk("mis_clr", misalign_o, 0);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit r, f, rdy;
            logic [31:0] rp;
            r   = ($urandom_range(0, 99) < 2);
            f   = ($urandom_range(0, 99) < 10);
            rdy = ($urandom_range(0, 99) < 65);
            rp  = $urandom;
            if ($urandom_range(0, 3) != 0) rp[2:0] = 3'b000;
            cyc(r, f, rp, rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
